// File: rtl/ysyx_22040759_mdu_ctrl_pkg.sv
// Op codes, FSM states and decode helpers shared by the RV64M multiply/divide unit.
package ysyx_22040759_mdu_ctrl_pkg;

    localparam logic [3:0] MDU_MUL    = 4'd0;
    localparam logic [3:0] MDU_MULH   = 4'd1;
    localparam logic [3:0] MDU_MULHSU = 4'd2;
    localparam logic [3:0] MDU_MULHU  = 4'd3;
    localparam logic [3:0] MDU_DIV    = 4'd4;
    localparam logic [3:0] MDU_DIVU   = 4'd5;
    localparam logic [3:0] MDU_REM    = 4'd6;
    localparam logic [3:0] MDU_REMU   = 4'd7;
    localparam logic [3:0] MDU_MULW   = 4'd8;
    localparam logic [3:0] MDU_DIVW   = 4'd9;
    localparam logic [3:0] MDU_DIVUW  = 4'd10;
    localparam logic [3:0] MDU_REMW   = 4'd11;
    localparam logic [3:0] MDU_REMUW  = 4'd12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mdu_state_t;

    // Codes above REMUW are executed as a plain mul.
    function automatic logic [3:0] f_legal(input logic [3:0] op);
        return (op > MDU_REMUW) ? MDU_MUL : op;
    endfunction

    function automatic logic f_is_word(input logic [3:0] op);
        return op >= MDU_MULW;
    endfunction

    function automatic logic f_is_div(input logic [3:0] op);
        return (op >= MDU_DIV && op <= MDU_REMU) || (op >= MDU_DIVW && op <= MDU_REMUW);
    endfunction

    function automatic logic f_is_rem(input logic [3:0] op);
        return op == MDU_REM || op == MDU_REMU || op == MDU_REMW || op == MDU_REMUW;
    endfunction

    function automatic logic f_sgn1(input logic [3:0] op);
        return op == MDU_MULH || op == MDU_MULHSU || op == MDU_DIV || op == MDU_REM
            || op == MDU_DIVW || op == MDU_REMW;
    endfunction

    function automatic logic f_sgn2(input logic [3:0] op);
        return op == MDU_MULH || op == MDU_DIV || op == MDU_REM
            || op == MDU_DIVW || op == MDU_REMW;
    endfunction

endpackage

// File: rtl/ysyx_22040759_mdu_ctrl_iter.sv
// One combinational iteration of the shift-add multiplier / restoring divider,
// plus the operand magnitude helpers used when an op is accepted.
module ysyx_22040759_mdu_iter #(
    parameter int XLEN = 64
) (
    input  logic              i_is_div,
    input  logic [2*XLEN-1:0] i_acc,
    input  logic [XLEN-1:0]   i_opnd,
    output logic [2*XLEN-1:0] o_acc,
    input  logic [XLEN-1:0]   i_x1,
    input  logic [XLEN-1:0]   i_x2,
    input  logic              i_neg1,
    input  logic              i_neg2,
    output logic [XLEN-1:0]   o_mag1,
    output logic [XLEN-1:0]   o_mag2
);
    logic [XLEN:0]   w_add;
    logic [XLEN:0]   w_top;
    logic [XLEN-1:0] w_sub;
    logic            w_ge;

    assign o_mag1 = i_neg1 ? -i_x1 : i_x1;
    assign o_mag2 = i_neg2 ? -i_x2 : i_x2;

    // Multiply: acc = {partial product, remaining multiplier bits}, add then shift right.
    assign w_add = {1'b0, i_acc[2*XLEN-1:XLEN]}
                 + (i_acc[0] ? {1'b0, i_opnd} : {(XLEN+1){1'b0}});

    // Divide: the shifted partial remainder needs XLEN+1 bits; the difference always fits XLEN.
    assign w_top = i_acc[2*XLEN-1:XLEN-1];
    assign w_ge  = w_top >= {1'b0, i_opnd};
    assign w_sub = w_top[XLEN-1:0] - i_opnd;

    always_comb begin
        o_acc = {w_add, i_acc[XLEN-1:1]};
        if (i_is_div) begin
            if (w_ge) o_acc = {w_sub, i_acc[XLEN-2:0], 1'b1};
            else      o_acc = {i_acc[2*XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/ysyx_22040759_mdu_ctrl.sv
// Iterative RV64M multiply/divide unit: IDLE/CALC/DONE sequencer, operand latches,
// iteration counter and final sign fix-up; one operation in flight at a time.
module ysyx_22040759_mdu_ctrl
    import ysyx_22040759_mdu_ctrl_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    localparam int HALF = XLEN / 2;

    mdu_state_t        r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [3:0]        r_op;
    logic              r_neg;
    logic [XLEN-1:0]   r_opnd;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_result;

    logic [3:0]        w_op;
    logic              w_word, w_div, w_rem, w_sgn1, w_sgn2;
    logic [XLEN-1:0]   w_x1, w_x2, w_mag1, w_mag2, w_min, w_spec_res;
    logic              w_neg1, w_neg2, w_div0, w_ovf, w_special, w_accept;
    logic [2*XLEN-1:0] w_acc_init, w_acc_nxt, w_prod;
    logic              w_r_word, w_r_div, w_r_rem;
    logic [XLEN-1:0]   w_quo, w_rem_v, w_dmag, w_dres, w_fix;

    assign w_op   = f_legal(op);
    assign w_word = f_is_word(w_op);
    assign w_div  = f_is_div(w_op);
    assign w_rem  = f_is_rem(w_op);
    assign w_sgn1 = f_sgn1(w_op);
    assign w_sgn2 = f_sgn2(w_op);

    // W ops see only the low half, sign- or zero-extended to full width.
    assign w_x1 = !w_word ? src1 : w_sgn1 ? {{HALF{src1[HALF-1]}}, src1[HALF-1:0]}
                                          : {{HALF{1'b0}}, src1[HALF-1:0]};
    assign w_x2 = !w_word ? src2 : w_sgn2 ? {{HALF{src2[HALF-1]}}, src2[HALF-1:0]}
                                          : {{HALF{1'b0}}, src2[HALF-1:0]};
    assign w_neg1 = w_sgn1 & w_x1[XLEN-1];
    assign w_neg2 = w_sgn2 & w_x2[XLEN-1];

    assign w_min = w_word ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    assign w_div0    = w_div && (w_x2 == '0);
    assign w_ovf     = w_div && w_sgn1 && (w_x1 == w_min) && (w_x2 == '1);
    assign w_special = w_div0 | w_ovf;
    assign w_spec_res = w_rem ? (w_div0 ? (w_word ? {{HALF{src1[HALF-1]}}, src1[HALF-1:0]} : src1)
                                        : '0)
                              : (w_div0 ? '1 : w_x1);

    // W divides start with the dividend at the top of the low half so 32 steps consume it.
    assign w_acc_init = !w_div ? {{XLEN{1'b0}}, w_mag2}
                      : w_word ? {{XLEN{1'b0}}, w_mag1[HALF-1:0], {HALF{1'b0}}}
                               : {{XLEN{1'b0}}, w_mag1};

    assign in_ready  = rst && (r_state == IDLE) && !flush;
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign result    = r_result;

    assign w_r_word = f_is_word(r_op);
    assign w_r_div  = f_is_div(r_op);
    assign w_r_rem  = f_is_rem(r_op);

    ysyx_22040759_mdu_iter #(.XLEN(XLEN)) u_iter (
        .i_is_div (w_r_div),
        .i_acc    (r_acc),
        .i_opnd   (r_opnd),
        .o_acc    (w_acc_nxt),
        .i_x1     (w_x1),
        .i_x2     (w_x2),
        .i_neg1   (w_neg1),
        .i_neg2   (w_neg2),
        .o_mag1   (w_mag1),
        .o_mag2   (w_mag2)
    );

    assign w_prod  = r_neg ? -w_acc_nxt : w_acc_nxt;
    assign w_quo   = w_r_word ? {{HALF{1'b0}}, w_acc_nxt[HALF-1:0]} : w_acc_nxt[XLEN-1:0];
    assign w_rem_v = w_r_word ? {{HALF{1'b0}}, w_acc_nxt[XLEN+HALF-1:XLEN]}
                              : w_acc_nxt[2*XLEN-1:XLEN];
    assign w_dmag  = w_r_rem ? w_rem_v : w_quo;
    assign w_dres  = r_neg ? -w_dmag : w_dmag;

    always_comb begin
        w_fix = w_dres;
        case (r_op)
            MDU_MUL:                         w_fix = w_prod[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: w_fix = w_prod[2*XLEN-1:XLEN];
            MDU_MULW:                        w_fix = {{HALF{w_acc_nxt[XLEN-1]}}, w_acc_nxt[XLEN-1:HALF]};
            MDU_DIVW, MDU_DIVUW, MDU_REMW, MDU_REMUW:
                                             w_fix = {{HALF{w_dres[HALF-1]}}, w_dres[HALF-1:0]};
            default:                         w_fix = w_dres;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = w_special ? DONE : CALC;
            CALC:    if (r_cnt == '0) w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (flush) w_state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_cnt <= w_word ? CNT_W'(HALF - 1) : CNT_W'(XLEN - 1);
            if (w_special) r_result <= w_spec_res;
        end else if (r_state == CALC) begin
            if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
            else if (!flush) r_result <= w_fix;
        end
    end

    // Operand latches and accumulator: don't-care until the next accept, so no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op   <= w_op;
            r_neg  <= w_rem ? w_neg1 : (w_neg1 ^ w_neg2);
            r_opnd <= w_div ? w_mag2 : w_mag1;
            r_acc  <= w_acc_init;
        end else if (r_state == CALC) begin
            r_acc <= w_acc_nxt;
        end
    end

endmodule

// File: tb/tb_ysyx_22040759_mdu_ctrl.sv
// Scoreboard bench for the multiply/divide unit: directed corner cases plus random ops
// compared against an arithmetic reference model.
module tb_ysyx_22040759_mdu_ctrl;
    import ysyx_22040759_mdu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, flush, out_valid, out_ready, busy;
    logic [3:0]  op;
    logic [63:0] src1, src2, result;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit rdy_rand = 1'b0;
    bit rdy_val  = 1'b1;

    typedef struct {
        logic [63:0] res;
        int          cyc;
    } exp_t;
    exp_t q[$];

    ysyx_22040759_mdu_ctrl #(.XLEN(64), .CNT_W(7)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src1      (src1),
        .src2      (src2),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    function automatic logic [63:0] ref_result(input logic [3:0] o, input logic [63:0] a,
                                               input logic [63:0] b);
        logic signed [127:0] pa, pb, pp;
        logic [127:0]        up;
        logic signed [63:0]  sa, sb;
        logic signed [31:0]  wa, wb;
        logic [31:0]         ua, ub;
        bit                  ovf64, ovf32;
        sa = a; sb = b; wa = a[31:0]; wb = b[31:0]; ua = a[31:0]; ub = b[31:0];
        ovf64 = (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
        ovf32 = (ua == 32'h8000_0000) && (ub == 32'hFFFF_FFFF);
        case (o)
            MDU_MULH: begin
                pa = {{64{a[63]}}, a}; pb = {{64{b[63]}}, b}; pp = pa * pb;
                return pp[127:64];
            end
            MDU_MULHSU: begin
                pa = {{64{a[63]}}, a}; pb = {64'd0, b}; pp = pa * pb;
                return pp[127:64];
            end
            MDU_MULHU: begin
                up = {64'd0, a} * {64'd0, b};
                return up[127:64];
            end
            MDU_DIV:   return (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : ovf64 ? a : 64'(sa / sb);
            MDU_DIVU:  return (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
            MDU_REM:   return (b == 0) ? a : ovf64 ? 64'd0 : 64'(sa % sb);
            MDU_REMU:  return (b == 0) ? a : a % b;
            MDU_MULW:  return sext32(ua * ub);
            MDU_DIVW:  return (ub == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : ovf32 ? sext32(ua) : sext32(32'(wa / wb));
            MDU_DIVUW: return (ub == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : sext32(ua / ub);
            MDU_REMW:  return (ub == 0) ? sext32(ua) : ovf32 ? 64'd0 : sext32(32'(wa % wb));
            MDU_REMUW: return (ub == 0) ? sext32(ua) : sext32(ua % ub);
            default:   return a * b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
        case (o)
            MDU_DIV, MDU_REM:
                return ((b == 0) || (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF)) ? 1 : 65;
            MDU_DIVU, MDU_REMU:   return (b == 0) ? 1 : 65;
            MDU_DIVW, MDU_REMW:
                return ((b[31:0] == 0) || (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)) ? 1 : 33;
            MDU_DIVUW, MDU_REMUW: return (b[31:0] == 0) ? 1 : 33;
            MDU_MULW:             return 33;
            default:              return 65;
        endcase
    endfunction

    function automatic logic [63:0] pick();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 6))
            0:       return 64'd0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'($urandom_range(0, 20));
            4:       return {{32{r[31]}}, r};
            5:       return 64'h0000_0000_8000_0000;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic issue(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] e, input int lat, input bit push, output int acc_cyc);
        int w;
        w = 0;
        acc_cyc = -1;
        @(negedge clk);
        while (!in_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 64'(in_ready), 64'd1);
            return;
        end
        in_valid = 1'b1; op = o; src1 = a; src2 = b;
        acc_cyc = cyc + 1;
        if (push) q.push_back('{e, cyc + 1 + lat});
        @(negedge clk);
        in_valid = 1'b0;
        op = 4'($urandom); src1 = {$urandom, $urandom}; src2 = {$urandom, $urandom};
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (q.size() != 0 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", 64'(q.size()), 64'd0);
            q.delete();
        end
        @(negedge clk);
    endtask

    initial begin : ready_driver
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_val;
        end
    end

    initial begin : monitor
        bit seen;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst && out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", 64'd1, 64'd0);
                end else begin
                    if (!seen) begin
                        chk("latency", 64'(cyc + 1), 64'(q[0].cyc));
                        seen = 1'b1;
                    end
                    chk("result", result, q[0].res);
                    if (out_ready) begin
                        void'(q.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    logic [3:0]  d_op  [14];
    logic [63:0] d_a   [14];
    logic [63:0] d_b   [14];
    logic [63:0] d_exp [14];
    int          d_lat [14];

    initial begin : stimulus
        int c0;
        logic [3:0]  ro;
        logic [63:0] ra, rb;

        d_op  = '{MDU_MUL, MDU_MULH, MDU_DIVW, MDU_REMW, MDU_DIVU, MDU_REMU, MDU_REM,
                  MDU_DIVUW, MDU_DIV, MDU_REMW, MDU_MULHU, 4'd15, MDU_MULW, MDU_DIVW};
        d_a   = '{64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0000_8000_0000,
                  64'h0000_0000_8000_0000, 64'd100, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9,
                  64'hFFFF_FFFF_FFFF_FFFE, 64'h8000_0000_0000_0000, 64'h0000_0001_8000_0000,
                  64'h8000_0000_0000_0000, 64'd3, 64'h1234_5678_FFFF_FFFF, 64'h0000_0000_FFFF_FFF9};
        d_b   = '{64'd7, 64'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0,
                  64'd2, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hABCD_0000_0000_0000, 64'd4, 64'd5,
                  64'd3, 64'd2};
        d_exp = '{64'hFFFF_FFFF_FFFF_FFEB, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000,
                  64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd100, 64'hFFFF_FFFF_FFFF_FFFF,
                  64'h0000_0000_7FFF_FFFF, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_8000_0000,
                  64'd2, 64'd15, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFD};
        d_lat = '{65, 65, 1, 1, 1, 1, 65, 33, 1, 1, 65, 65, 33, 33};

        rst = 1'b0; in_valid = 1'b0; flush = 1'b0; op = 4'd0; src1 = '0; src2 = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd0);
        chk("reset_result", result, 64'd0);
        rst = 1'b1;

        for (int i = 0; i < 14; i++) issue(d_op[i], d_a[i], d_b[i], d_exp[i], d_lat[i], 1'b1, c0);
        drain();

        // flush with in_valid while idle must not accept
        flush = 1'b1; in_valid = 1'b1; op = MDU_MUL; src1 = 64'd9; src2 = 64'd9;
        #1;
        chk("flush_idle_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("flush_idle_busy", 64'(busy), 64'd0);

        // kill a divide mid-flight, then start a mulhu right after
        issue(MDU_DIV, 64'd1000, 64'd7, 64'd0, 0, 1'b0, c0);
        while (cyc < c0 + 19) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush_calc_busy", 64'(busy), 64'd0);
        chk("flush_calc_out_valid", 64'(out_valid), 64'd0);
        chk("flush_calc_in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1; op = MDU_MULHU; src1 = 64'h8000_0000_0000_0000; src2 = 64'd4;
        q.push_back('{64'd2, cyc + 1 + 65});
        @(negedge clk);
        in_valid = 1'b0;
        drain();

        // stall in DONE for 10 cycles
        rdy_val = 1'b0;
        repeat (2) @(negedge clk);
        issue(MDU_DIVU, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b1, c0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_result", result, 64'hFFFF_FFFF_FFFF_FFFF);
        end
        rdy_val = 1'b1;
        drain();

        rdy_rand = 1'b1;
        for (int i = 0; i < 30; i++) begin
            ro = 4'($urandom_range(0, 15));
            ra = pick();
            rb = pick();
            issue(ro, ra, rb, ref_result(ro, ra, rb), ref_lat(ro, ra, rb), 1'b1, c0);
        end
        drain();
        rdy_rand = 1'b0;
        rdy_val  = 1'b1;

        // reset in the middle of a calculation
        issue(MDU_MUL, 64'd12345, 64'd678, 64'd0, 0, 1'b0, c0);
        repeat (10) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("midreset_out_valid", 64'(out_valid), 64'd0);
        chk("midreset_busy", 64'(busy), 64'd0);
        chk("midreset_in_ready", 64'(in_ready), 64'd0);
        chk("midreset_result", result, 64'd0);
        rst = 1'b1;
        repeat (80) @(negedge clk);
        #1;
        chk("midreset_still_idle", 64'(busy), 64'd0);
        chk("queue_empty", 64'(q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
